// File: rtl/msg_tx_pkg.sv
// Shared types and constants for the message transmit scheduler.
package msg_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_START,
      ST_BUSY,
      ST_GAP
   } tx_state_e;

   localparam logic [31:0] HEADER_DEF = 32'hFDF7EB90;

   localparam int FTYPE_W = 4;
   localparam int ID_W    = 8;
   localparam int CNT_W   = 16;

   localparam logic [FTYPE_W-1:0] FT_DATA     = 4'h0;
   localparam logic [FTYPE_W-1:0] FT_CMD      = 4'h1;
   localparam logic [FTYPE_W-1:0] FT_ACK      = 4'h2;
   localparam logic [FTYPE_W-1:0] FT_STATUS   = 4'h3;
   localparam logic [FTYPE_W-1:0] FT_HDR_ONLY = 4'h4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic [NUM_CH-1:0] grant,
   output logic [CH_W-1:0]   idx,
   output logic              valid
);

   int c;

   // Walk offsets from far to near so the nearest hit is the one left standing.
   always_comb begin
      grant = '0;
      idx   = '0;
      valid = 1'b0;
      c     = 0;
      for (int off = NUM_CH - 1; off >= 0; off--) begin
         c = (int'(ptr) + off) % NUM_CH;
         if (req[c]) begin
            grant    = '0;
            grant[c] = 1'b1;
            idx      = CH_W'(c);
            valid    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/msg_tx_scheduler.sv
// Round-robin scheduler sharing one msg_transmit_driver between NUM_CH sources,
// with per-channel frame counters and a BUSY completion timeout.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for an eligible channel; grant cleared
//   ST_LOAD  | granted channel's fields latched, held stable one cycle
//   ST_START | driver start pulse
//   ST_BUSY  | driver owns the granted FIFO; wait for done or timeout
//   ST_GAP   | inter-frame idle before next arbitration
module msg_tx_scheduler
   import msg_tx_pkg::*;
#(
   parameter int          NUM_CH         = 4,
   parameter int          CH_W           = 2,
   parameter logic [31:0] HEADER         = HEADER_DEF,
   parameter int          TIMEOUT_CYCLES = 65535,
   parameter int          GAP_CYCLES     = 4
) (
   input  logic                      sys_clk_i,
   input  logic                      rst_i,
   input  logic [NUM_CH-1:0]         ch_en_i,
   input  logic [NUM_CH-1:0]         ch_req_i,
   input  logic [NUM_CH*FTYPE_W-1:0] ch_frame_type_i,
   input  logic [NUM_CH*ID_W-1:0]    ch_src_id_i,
   input  logic [NUM_CH*ID_W-1:0]    ch_des_id_i,
   input  logic [NUM_CH*ID_W-1:0]    ch_data_type_i,
   input  logic [NUM_CH*ID_W-1:0]    ch_data_channel_i,
   input  logic [NUM_CH*CNT_W-1:0]   ch_data_count_i,
   input  logic [NUM_CH-1:0]         ch_empty_i,
   input  logic [NUM_CH*ID_W-1:0]    ch_din_i,
   output logic [NUM_CH-1:0]         ch_rd_en_o,
   output logic                      drv_start_pluse_o,
   output logic [31:0]               drv_header_o,
   output logic [FTYPE_W-1:0]        drv_frame_type_o,
   output logic [CNT_W-1:0]          drv_frame_cnt_o,
   output logic [ID_W-1:0]           drv_src_id_o,
   output logic [ID_W-1:0]           drv_des_id_o,
   output logic [ID_W-1:0]           drv_data_type_o,
   output logic [ID_W-1:0]           drv_data_channel_o,
   input  logic                      drv_rd_en_i,
   output logic [ID_W-1:0]           drv_din_o,
   output logic [CNT_W-1:0]          drv_data_count_o,
   output logic                      drv_empty_o,
   input  logic                      drv_done_i,
   output logic [NUM_CH-1:0]         grant_o,
   output logic                      busy_o,
   output logic                      timeout_o,
   output logic [CH_W-1:0]           timeout_ch_o
);

   localparam int TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   tx_state_e                      state_q, state_d;
   logic [CH_W-1:0]                ptr_q;
   logic [CH_W-1:0]                idx_q;
   logic [NUM_CH-1:0][CNT_W-1:0]   frame_cnt_q;
   logic [TMR_W-1:0]               tmr_q;

   logic [NUM_CH-1:0] elig;
   logic [NUM_CH-1:0] arb_grant;
   logic [CH_W-1:0]   arb_idx;
   logic              arb_valid;
   logic              tmr_zero;
   logic              done_hit;
   logic              tmo_hit;

   assign elig     = ch_en_i & ch_req_i;
   assign tmr_zero = (tmr_q == '0);
   assign done_hit = (state_q == ST_BUSY) && drv_done_i;
   assign tmo_hit  = (state_q == ST_BUSY) && !drv_done_i && tmr_zero;

   rr_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (
      .req   (elig),
      .ptr   (ptr_q),
      .grant (arb_grant),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   always_ff @(posedge sys_clk_i) begin
      if (rst_i) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d           = state_q;
      drv_start_pluse_o = 1'b0;
      busy_o            = (state_q != ST_IDLE);
      case (state_q)
         ST_IDLE:  if (arb_valid) state_d = ST_LOAD;
         ST_LOAD:  state_d = ST_START;
         ST_START: begin
            drv_start_pluse_o = 1'b1;
            state_d           = ST_BUSY;
         end
         ST_BUSY:  if (done_hit || tmo_hit) state_d = ST_GAP;
         ST_GAP:   if (tmr_zero) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk_i) begin
      if (rst_i) begin
         ptr_q              <= '0;
         idx_q              <= '0;
         frame_cnt_q        <= '0;
         tmr_q              <= '0;
         grant_o            <= '0;
         timeout_o          <= 1'b0;
         timeout_ch_o       <= '0;
         drv_frame_type_o   <= '0;
         drv_frame_cnt_o    <= '0;
         drv_src_id_o       <= '0;
         drv_des_id_o       <= '0;
         drv_data_type_o    <= '0;
         drv_data_channel_o <= '0;
      end else begin
         timeout_o <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (arb_valid) begin
                  grant_o            <= arb_grant;
                  idx_q              <= arb_idx;
                  drv_frame_type_o   <= ch_frame_type_i[int'(arb_idx)*FTYPE_W +: FTYPE_W];
                  drv_src_id_o       <= ch_src_id_i[int'(arb_idx)*ID_W +: ID_W];
                  drv_des_id_o       <= ch_des_id_i[int'(arb_idx)*ID_W +: ID_W];
                  drv_data_type_o    <= ch_data_type_i[int'(arb_idx)*ID_W +: ID_W];
                  drv_data_channel_o <= ch_data_channel_i[int'(arb_idx)*ID_W +: ID_W];
                  drv_frame_cnt_o    <= frame_cnt_q[arb_idx];
               end
            end
            ST_START: tmr_q <= TMR_W'(TIMEOUT_CYCLES - 1);
            ST_BUSY: begin
               if (done_hit || tmo_hit) begin
                  tmr_q <= TMR_W'(GAP_CYCLES - 1);
                  ptr_q <= (idx_q == CH_W'(NUM_CH - 1)) ? '0 : idx_q + 1'b1;
                  // done outranks a coincident timeout
                  if (done_hit) begin
                     frame_cnt_q[idx_q] <= frame_cnt_q[idx_q] + 1'b1;
                  end else begin
                     timeout_o    <= 1'b1;
                     timeout_ch_o <= idx_q;
                  end
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            ST_GAP: begin
               if (tmr_zero) grant_o <= '0;
               else          tmr_q   <= tmr_q - 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign drv_header_o = HEADER;
   assign ch_rd_en_o   = (drv_rd_en_i && state_q == ST_BUSY) ? grant_o : '0;

   always_comb begin
      drv_din_o        = '0;
      drv_data_count_o = '0;
      drv_empty_o      = 1'b1;
      if (|grant_o) begin
         drv_din_o        = ch_din_i[int'(idx_q)*ID_W +: ID_W];
         drv_data_count_o = ch_data_count_i[int'(idx_q)*CNT_W +: CNT_W];
         drv_empty_o      = ch_empty_i[idx_q];
      end
   end

endmodule

// File: tb/tb_msg_tx_scheduler.sv
// Directed bench for msg_tx_scheduler: arbitration order, field latching,
// routing, counter wrap, timeout and mid-frame reset.
module tb_msg_tx_scheduler;

   logic        sys_clk_i = 1'b0;
   logic        rst_i;
   logic [3:0]  ch_en_i, ch_req_i, ch_empty_i, ch_rd_en_o, grant_o;
   logic [15:0] ch_frame_type_i;
   logic [31:0] ch_src_id_i, ch_des_id_i, ch_data_type_i, ch_data_channel_i, ch_din_i;
   logic [63:0] ch_data_count_i;
   logic        drv_start_pluse_o, drv_rd_en_i, drv_empty_o, drv_done_i, busy_o, timeout_o;
   logic [31:0] drv_header_o;
   logic [3:0]  drv_frame_type_o;
   logic [15:0] drv_frame_cnt_o, drv_data_count_o;
   logic [7:0]  drv_src_id_o, drv_des_id_o, drv_data_type_o, drv_data_channel_o, drv_din_o;
   logic [1:0]  timeout_ch_o;

   int n_checks = 0;
   int n_errors = 0;
   int cyc;

   always #5 sys_clk_i = ~sys_clk_i;

   msg_tx_scheduler #(
      .NUM_CH(4), .CH_W(2), .HEADER(32'hFDF7EB90), .TIMEOUT_CYCLES(16), .GAP_CYCLES(4)
   ) dut (
      .sys_clk_i          (sys_clk_i),
      .rst_i              (rst_i),
      .ch_en_i            (ch_en_i),
      .ch_req_i           (ch_req_i),
      .ch_frame_type_i    (ch_frame_type_i),
      .ch_src_id_i        (ch_src_id_i),
      .ch_des_id_i        (ch_des_id_i),
      .ch_data_type_i     (ch_data_type_i),
      .ch_data_channel_i  (ch_data_channel_i),
      .ch_data_count_i    (ch_data_count_i),
      .ch_empty_i         (ch_empty_i),
      .ch_din_i           (ch_din_i),
      .ch_rd_en_o         (ch_rd_en_o),
      .drv_start_pluse_o  (drv_start_pluse_o),
      .drv_header_o       (drv_header_o),
      .drv_frame_type_o   (drv_frame_type_o),
      .drv_frame_cnt_o    (drv_frame_cnt_o),
      .drv_src_id_o       (drv_src_id_o),
      .drv_des_id_o       (drv_des_id_o),
      .drv_data_type_o    (drv_data_type_o),
      .drv_data_channel_o (drv_data_channel_o),
      .drv_rd_en_i        (drv_rd_en_i),
      .drv_din_o          (drv_din_o),
      .drv_data_count_o   (drv_data_count_o),
      .drv_empty_o        (drv_empty_o),
      .drv_done_i         (drv_done_i),
      .grant_o            (grant_o),
      .busy_o             (busy_o),
      .timeout_o          (timeout_o),
      .timeout_ch_o       (timeout_ch_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_ch(input int k, input logic [3:0] ft, input logic [7:0] src,
                         input logic [7:0] des, input logic [7:0] dt, input logic [7:0] dc,
                         input logic [15:0] cnt, input logic emp, input logic [7:0] din);
      ch_frame_type_i[k*4 +: 4]    = ft;
      ch_src_id_i[k*8 +: 8]        = src;
      ch_des_id_i[k*8 +: 8]        = des;
      ch_data_type_i[k*8 +: 8]     = dt;
      ch_data_channel_i[k*8 +: 8]  = dc;
      ch_data_count_i[k*16 +: 16]  = cnt;
      ch_empty_i[k]                = emp;
      ch_din_i[k*8 +: 8]           = din;
   endtask

   task automatic wait_start(input string tag, output int n);
      n = 0;
      do begin
         @(negedge sys_clk_i);
         n++;
      end while (!drv_start_pluse_o && n < 40);
      chk({tag, "_start_seen"}, drv_start_pluse_o, 1);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      do begin
         @(negedge sys_clk_i);
         n++;
      end while (busy_o && n < 40);
      chk({tag, "_idle"}, busy_o, 0);
   endtask

   task automatic finish_frame();
      drv_done_i = 1'b1;
      @(negedge sys_clk_i);
      drv_done_i = 1'b0;
   endtask

   int exp_ch  [4] = '{2, 0, 2, 0};
   int exp_cnt [4] = '{0, 1, 1, 2};

   initial begin
      rst_i = 1'b1;
      ch_en_i = '0; ch_req_i = '0; ch_empty_i = '1;
      ch_frame_type_i = '0; ch_src_id_i = '0; ch_des_id_i = '0; ch_data_type_i = '0;
      ch_data_channel_i = '0; ch_data_count_i = '0; ch_din_i = '0;
      drv_rd_en_i = 1'b0; drv_done_i = 1'b0;
      repeat (3) @(negedge sys_clk_i);

      chk("rst_busy", busy_o, 0);
      chk("rst_grant", grant_o, 0);
      chk("rst_start", drv_start_pluse_o, 0);
      chk("rst_tmo", timeout_o, 0);
      chk("rst_tmo_ch", timeout_ch_o, 0);
      chk("rst_empty", drv_empty_o, 1);
      chk("rst_src", drv_src_id_o, 0);
      chk("rst_fcnt", drv_frame_cnt_o, 0);
      chk("header", drv_header_o, 32'hFDF7EB90);
      rst_i = 1'b0;

      // single channel frame
      ch_en_i = 4'hF;
      set_ch(0, 4'h1, 8'h11, 8'h22, 8'h33, 8'h44, 16'd99, 1'b0, 8'hA5);
      ch_req_i = 4'b0001;
      wait_start("t1", cyc);
      chk("t1_lat", cyc, 2);
      chk("t1_grant", grant_o, 4'b0001);
      chk("t1_src", drv_src_id_o, 8'h11);
      chk("t1_des", drv_des_id_o, 8'h22);
      chk("t1_dtype", drv_data_type_o, 8'h33);
      chk("t1_dchan", drv_data_channel_o, 8'h44);
      chk("t1_ftype", drv_frame_type_o, 4'h1);
      chk("t1_fcnt", drv_frame_cnt_o, 0);
      chk("t1_dcount", drv_data_count_o, 99);
      chk("t1_din", drv_din_o, 8'hA5);
      chk("t1_empty", drv_empty_o, 0);
      drv_rd_en_i = 1'b1;
      #1 chk("t1_rd_start", ch_rd_en_o, 4'b0000);
      drv_rd_en_i = 1'b0;
      ch_req_i = '0;
      @(negedge sys_clk_i);
      drv_rd_en_i = 1'b1;
      #1 chk("t1_rd_busy1", ch_rd_en_o, 4'b0001);
      drv_rd_en_i = 1'b0;
      #1 chk("t1_rd_busy0", ch_rd_en_o, 4'b0000);
      finish_frame();
      chk("t1_gap_busy", busy_o, 1);
      chk("t1_gap_grant", grant_o, 4'b0001);
      repeat (3) @(negedge sys_clk_i);
      chk("t1_gap_end_busy", busy_o, 1);
      @(negedge sys_clk_i);
      chk("t1_idle_busy", busy_o, 0);
      chk("t1_idle_grant", grant_o, 0);

      // ch0 and ch2 alternate; pointer sits at 1 after the ch0 frame
      set_ch(2, 4'h2, 8'h55, 8'h56, 8'h57, 8'h58, 16'd7, 1'b0, 8'h3C);
      ch_req_i = 4'b0101;
      for (int f = 0; f < 4; f++) begin
         wait_start("t2", cyc);
         chk("t2_lat", cyc, (f == 0) ? 2 : 6);
         chk("t2_grant", grant_o, 32'd1 << exp_ch[f]);
         chk("t2_fcnt", drv_frame_cnt_o, exp_cnt[f]);
         chk("t2_src", drv_src_id_o, (exp_ch[f] == 2) ? 8'h55 : 8'h11);
         @(negedge sys_clk_i);
         if (f == 3) ch_req_i = '0;
         finish_frame();
      end
      wait_idle("t2");

      // header-only frame on ch1
      set_ch(1, 4'h4, 8'h66, 8'h77, 8'h01, 8'h02, 16'd0, 1'b1, 8'h00);
      ch_req_i = 4'b0010;
      wait_start("t3", cyc);
      chk("t3_lat", cyc, 2);
      chk("t3_grant", grant_o, 4'b0010);
      chk("t3_empty", drv_empty_o, 1);
      chk("t3_dcount", drv_data_count_o, 0);
      chk("t3_ftype", drv_frame_type_o, 4'h4);
      chk("t3_fcnt", drv_frame_cnt_o, 0);
      ch_req_i = '0;
      @(negedge sys_clk_i);
      drv_rd_en_i = 1'b1;
      #1 chk("t3_rd", ch_rd_en_o, 4'b0010);
      drv_rd_en_i = 1'b0;
      finish_frame();
      wait_idle("t3");

      // ch3 counter wrap: counters ch3..ch0 = FFFF, 2, 1, 3
      force dut.frame_cnt_q = {16'hFFFF, 16'd2, 16'd1, 16'd3};
      #1 release dut.frame_cnt_q;
      set_ch(3, 4'h3, 8'h99, 8'h9A, 8'h9B, 8'h9C, 16'd5, 1'b0, 8'h5A);
      ch_req_i = 4'b1000;
      wait_start("t4", cyc);
      chk("t4_grant", grant_o, 4'b1000);
      chk("t4_fcnt_max", drv_frame_cnt_o, 16'hFFFF);
      @(negedge sys_clk_i);
      finish_frame();
      wait_start("t4b", cyc);
      chk("t4_lat", cyc, 6);
      chk("t4_fcnt_wrap", drv_frame_cnt_o, 16'h0000);
      ch_req_i = '0;
      @(negedge sys_clk_i);
      finish_frame();
      wait_idle("t4");

      // timeout on ch2
      ch_req_i = 4'b0100;
      wait_start("t5", cyc);
      chk("t5_fcnt", drv_frame_cnt_o, 2);
      ch_req_i = '0;
      cyc = 0;
      do begin
         @(negedge sys_clk_i);
         cyc++;
      end while (!timeout_o && cyc < 40);
      chk("t5_tmo_lat", cyc, 17);
      chk("t5_tmo_ch", timeout_ch_o, 2);
      chk("t5_tmo_grant", grant_o, 4'b0100);
      @(negedge sys_clk_i);
      chk("t5_tmo_pulse", timeout_o, 0);
      wait_idle("t5");

      // done coincident with the terminal timeout cycle
      ch_req_i = 4'b0100;
      wait_start("t5b", cyc);
      chk("t5b_fcnt_kept", drv_frame_cnt_o, 2);
      ch_req_i = '0;
      repeat (16) @(negedge sys_clk_i);
      chk("t5b_tmo_pre", timeout_o, 0);
      finish_frame();
      chk("t5b_no_tmo", timeout_o, 0);
      wait_idle("t5b");

      // reset mid-BUSY
      ch_req_i = 4'b0100;
      wait_start("t6", cyc);
      chk("t6_fcnt", drv_frame_cnt_o, 3);
      ch_req_i = '0;
      @(negedge sys_clk_i);
      drv_rd_en_i = 1'b1;
      #1 chk("t6_rd", ch_rd_en_o, 4'b0100);
      rst_i = 1'b1;
      @(negedge sys_clk_i);
      chk("t6_busy", busy_o, 0);
      chk("t6_grant", grant_o, 0);
      chk("t6_rd_rst", ch_rd_en_o, 0);
      chk("t6_src", drv_src_id_o, 0);
      chk("t6_fcnt_rst", drv_frame_cnt_o, 0);
      rst_i = 1'b0;
      drv_rd_en_i = 1'b0;
      drv_done_i = 1'b1;
      @(negedge sys_clk_i);
      drv_done_i = 1'b0;
      chk("t6_done_idle", busy_o, 0);
      ch_req_i = 4'b0110;
      wait_start("t6b", cyc);
      chk("t6b_lat", cyc, 2);
      chk("t6b_grant", grant_o, 4'b0010);
      chk("t6b_fcnt", drv_frame_cnt_o, 0);
      ch_req_i = 4'b0100;
      @(negedge sys_clk_i);
      finish_frame();
      wait_start("t6c", cyc);
      chk("t6c_grant", grant_o, 4'b0100);
      chk("t6c_fcnt", drv_frame_cnt_o, 0);
      ch_req_i = '0;
      @(negedge sys_clk_i);
      finish_frame();
      wait_idle("t6c");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/msg_tx_scheduler.md
Name: msg_tx_scheduler

Overview:
Round-robin scheduler sharing one msg_transmit_driver between NUM_CH message sources (one byte FIFO plus header fields per source). It picks an eligible channel, presents that channel's header fields to the driver, fires the driver start pulse, and routes the driver's FIFO read port to the granted channel. It also owns the per-channel frame counters and a completion timeout. It sits between the per-channel FIFOs/config registers and the driver.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
CH_W, 2, index width, equals clog2(NUM_CH)
HEADER, 32'hFDF7EB90, frame header word presented to the driver
TIMEOUT_CYCLES, 65535, max BUSY cycles before abort
GAP_CYCLES, 4, idle cycles between consecutive frames

Ports:
sys_clk_i  in  1  single system clock
rst_i  in  1  synchronous reset, active-high
ch_en_i  in  NUM_CH  per-channel enable
ch_req_i  in  NUM_CH  level request "frame ready"
ch_frame_type_i  in  NUM_CH*4  packed per-channel frame type
ch_src_id_i / ch_des_id_i / ch_data_type_i / ch_data_channel_i  in  NUM_CH*8 each  packed per-channel IDs
ch_data_count_i  in  NUM_CH*16  per-channel FIFO fill
ch_empty_i  in  NUM_CH  per-channel FIFO empty
ch_din_i  in  NUM_CH*8  per-channel FIFO read data
ch_rd_en_o  out  NUM_CH  per-channel FIFO read enable
drv_start_pluse_o  out  1  driver start pulse
drv_header_o  out  32  equals HEADER
drv_frame_type_o  out  4  latched fields for the granted channel
drv_frame_cnt_o  out  16  latched fields for the granted channel
drv_src_id_o / drv_des_id_o / drv_data_type_o / drv_data_channel_o  out  8 each  latched fields for the granted channel
drv_rd_en_i  in  1  driver FIFO read request
drv_din_o  out  8  muxed FIFO data
drv_data_count_o  out  16  muxed fill count
drv_empty_o  out  1  muxed empty flag
drv_done_i  in  1  driver end-of-frame pulse
grant_o  out  NUM_CH  one-hot active grant
busy_o  out  1  high in any state except IDLE
timeout_o  out  1  one-cycle abort pulse
timeout_ch_o  out  CH_W  channel index of the last timeout

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge): state=IDLE; RR pointer=0; all frame counters=0; grant_o=0; busy_o=0; drv_start_pluse_o=0; timeout_o=0; timeout_ch_o=0; all latched drv_* fields=0. Reset mid-frame aborts immediately: the counter is not incremented and the driver is not notified.
- Eligibility: ch_en_i[k] & ch_req_i[k]. A channel with empty=1 and data_count=0 is eligible; it produces a header-only frame.
- FSM:
  - IDLE: if any channel is eligible, search from the RR pointer upward, wrapping. Grant the first hit k. Latch k's fields plus frame_cnt[k]. Go to LOAD.
  - LOAD: one cycle with fields stable. Go to START.
  - START: drv_start_pluse_o=1 for exactly this cycle. Go to BUSY.
  - BUSY: wait for drv_done_i or timeout.
  - GAP: count GAP_CYCLES, then go to IDLE.
- Latency: the start pulse is asserted 2 cycles after the IDLE cycle that samples the request.
- drv_* fields and grant_o hold from LOAD through GAP. grant_o clears on entry to IDLE.
- Routing (combinational):
  - ch_rd_en_o[k] = drv_rd_en_i & grant_o[k] & (state==BUSY).
  - drv_din_o, drv_data_count_o and drv_empty_o select the granted channel. With no grant: 0, 0, 1.
- Done: drv_done_i in BUSY sets frame_cnt[k] += 1 (16-bit, wraps 0xFFFF to 0x0000), sets the RR pointer to (k+1) mod NUM_CH, and goes to GAP. drv_done_i outside BUSY is ignored.
- Timeout: the BUSY counter reaches TIMEOUT_CYCLES-1 without done. Then timeout_o pulses 1 cycle, timeout_ch_o=k, frame_cnt is unchanged, the pointer still advances, and the FSM goes to GAP.
  - If done and timeout occur in the same cycle, done wins.
- Request or enable dropping after grant does not abort the frame. Field inputs changing after LOAD have no effect.

Decomposition:
- Shared package msg_tx_pkg: FSM state encoding, HEADER default, field widths (4/8/16), frame-type constants.
- Sub-module rr_arbiter (NUM_CH):
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, index, any-valid.
  - Purely combinational; reusable.

Test Plan:
- ch0 only, req=1, data_count=99, src 0x11, des 0x22: start pulse 2 cycles after req. Fields 0x11/0x22, frame_cnt=0. ch_rd_en_o[0] mirrors drv_rd_en_i. After done, frame_cnt[0]=1.
- ch0 and ch2 request together, pointer=0: grant order ch0, ch2, ch0, ch2. GAP_CYCLES idle cycles between each start pulse.
- ch1 frame_type 4, empty=1, data_count=0: granted. drv_empty_o=1, drv_data_count_o=0, start pulse issued.
- ch3 frame_cnt preloaded to 0xFFFF via 65535 done cycles (or a force): next frame presents 0xFFFF. Counter then wraps to 0x0000.
- BUSY with no done, TIMEOUT_CYCLES=16: timeout_o pulses at BUSY cycle 16, timeout_ch_o=granted index, frame_cnt unchanged, then IDLE after the gap. Same-cycle done+timeout increments the counter with no timeout_o.
- rst_i asserted mid-BUSY: next cycle busy_o=0, grant_o=0, ch_rd_en_o=0, counters 0.
